// File: rtl/pixel_capture_packer_pkg.sv
// rtl/pixel_capture_packer_pkg.sv - shared types, widths and frame geometry defaults for pixel_capture_packer
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 2
`endif

package pixel_capture_packer_pkg;

    localparam int PIX_W       = 16;
    localparam int WORD_W      = 2 * PIX_W;
    localparam int FRAME_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_GAP  = 2'd2,
        ST_FEND = 2'd3
    } cap_state_t;

endpackage

// File: rtl/pixel_capture_packer_pair_packer.sv
// rtl/pixel_capture_packer_pair_packer.sv - holds the even pixel and emits packed pixel-pair / flush writes
module pixel_pair_packer
    import pixel_capture_packer_pkg::*;
(
    input  logic              PCLK,
    input  logic              RST,
    input  logic              take,
    input  logic [PIX_W-1:0]  pix,
    input  logic              flush,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_data,
    output logic              pend_valid
);

    logic [PIX_W-1:0] pending;

    // Pair parity follows pend_valid, which is always clear at a line start.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (take) begin
                if (pend_valid) begin
                    wr_en      <= 1'b1;
                    wr_data    <= {pix, pending};
                    pend_valid <= 1'b0;
                end else begin
                    pending    <= pix;
                    pend_valid <= 1'b1;
                end
            end else if (flush && pend_valid) begin
                wr_en      <= 1'b1;
                wr_data    <= {{PIX_W{1'b0}}, pending};
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_capture_packer.sv
// rtl/pixel_capture_packer.sv - HSYNC-qualified pixel capture writing packed pixel pairs into a frame buffer
// Optional LINE_LENGTH_CHECK_EN: pulse line_err with line_done when a line's pixel count differs from IMG_WIDTH.
module pixel_capture_packer
    import pixel_capture_packer_pkg::*;
#(
    parameter int IMG_WIDTH  = `IMG_WIDTH,
    parameter int IMG_HEIGHT = `IMG_HEIGHT,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT / 2)
) (
    input  logic                   PCLK,
    input  logic                   RST,
    input  logic [PIX_W-1:0]       Pixel_DATA,
    input  logic                   HSYNC,
    input  logic                   VSYNC,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [WORD_W-1:0]      wr_data,
    output logic                   line_done,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   line_err
);

    localparam int                COL_W    = $clog2(IMG_WIDTH + 2);
    localparam int                LINE_W   = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0]  COL_END  = COL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0]  COL_SAT  = COL_W'(IMG_WIDTH + 1);
    localparam logic [LINE_W-1:0] LINE_END = LINE_W'(IMG_HEIGHT);

    cap_state_t        state, state_nxt;
    logic [COL_W-1:0]  col, col_eff;
    logic [LINE_W-1:0] line_cnt;
    logic              line_start, line_fall, in_line, take;
    logic              flush_wait, pend_valid;
    logic              vsync_unused;

    assign vsync_unused = VSYNC;

    always_comb begin
        state_nxt  = state;
        line_start = 1'b0;
        line_fall  = 1'b0;
        unique case (state)
            ST_IDLE: if (HSYNC) begin
                state_nxt  = ST_LINE;
                line_start = 1'b1;
            end
            ST_LINE: if (!HSYNC) begin
                state_nxt = ST_GAP;
                line_fall = 1'b1;
            end
            ST_GAP: if (line_cnt == LINE_END) begin
                state_nxt = ST_FEND;
            end else if (HSYNC) begin
                state_nxt  = ST_LINE;
                line_start = 1'b1;
            end
            ST_FEND: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        in_line = HSYNC && (line_start || state == ST_LINE);
        col_eff = line_start ? '0 : col;
        // Pixels past the line width are sampled but never packed.
        take    = in_line && (col_eff < COL_END);
    end

    pixel_pair_packer u_pair (
        .PCLK       (PCLK),
        .RST        (RST),
        .take       (take),
        .pix        (Pixel_DATA),
        .flush      (line_fall),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .pend_valid (pend_valid)
    );

    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            col        <= '0;
            line_cnt   <= '0;
            flush_wait <= 1'b0;
            wr_addr    <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            if (in_line) begin
                col <= (col_eff == COL_SAT) ? col_eff : col_eff + 1'b1;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            // An odd-length line spends one extra cycle writing its flush word before line_done.
            if (line_fall) begin
                line_cnt   <= line_cnt + 1'b1;
                flush_wait <= pend_valid;
                line_done  <= !pend_valid;
            end
            if (flush_wait) begin
                flush_wait <= 1'b0;
                line_done  <= 1'b1;
            end
            if (state == ST_FEND) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                wr_addr    <= '0;
                line_cnt   <= '0;
            end
        end
    end

`ifdef LINE_LENGTH_CHECK_EN
    logic len_bad;

    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            len_bad  <= 1'b0;
            line_err <= 1'b0;
        end else begin
            line_err <= 1'b0;
            if (line_fall) begin
                len_bad  <= (col != COL_END);
                line_err <= !pend_valid && (col != COL_END);
            end
            if (flush_wait) begin
                line_err <= len_bad;
            end
        end
    end
`else
    assign line_err = 1'b0;
`endif

endmodule
